// File: rtl/ofdm_symbol_mapper_if.sv
// Stream bundle between the QAM source, the subcarrier mapper and the IFFT.
// The mapper sits on the slave side; the driver/sink uses the master view.
interface ofdm_symbol_mapper_if #(
   parameter int WIDTH = 16,
   parameter int NFFT  = 64
);
   localparam int IW = $clog2(NFFT);

   logic signed [WIDTH-1:0] in_i;
   logic signed [WIDTH-1:0] in_q;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] out_i;
   logic signed [WIDTH-1:0] out_q;
   logic [IW-1:0]           out_idx;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_sop;
   logic                    out_eop;

   modport master (
      output in_i, in_q, in_valid, out_ready,
      input  in_ready, out_i, out_q, out_idx, out_valid, out_sop, out_eop
   );

   modport slave (
      input  in_i, in_q, in_valid, out_ready,
      output in_ready, out_i, out_q, out_idx, out_valid, out_sop, out_eop
   );
endinterface

// File: rtl/ofdm_symbol_mapper.sv
// OFDM subcarrier mapper: walks bins 0..NFFT-1 placing QAM data, LFSR-signed
// BPSK pilots and DC/guard nulls, with ready/valid on both sides.
module ofdm_symbol_mapper #(
   parameter int WIDTH         = 16,
   parameter int NFFT          = 64,
   parameter int NUSED         = 52,
   parameter int PILOT_SPACING = 13,
   parameter int PILOT_OFFSET  = 6,
   parameter int PILOT_AMP     = 8192
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 pilot_en,
   ofdm_symbol_mapper_if.slave  bus
);
   localparam int                      IW        = $clog2(NFFT);
   localparam int                      H         = NUSED / 2;
   localparam logic [IW-1:0]           LAST_IDX  = IW'(NFFT - 1);
   localparam logic signed [WIDTH-1:0] PILOT_POS = WIDTH'(PILOT_AMP);
   localparam logic signed [WIDTH-1:0] PILOT_NEG = WIDTH'(-PILOT_AMP);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MAP = 1'b1} state_t;
   typedef enum logic [1:0] {BIN_NULL = 2'd0, BIN_PILOT = 2'd1, BIN_DATA = 2'd2} bin_t;

   // Upper used carriers continue the ordinal count where the lower half stopped.
   function automatic bin_t classify(input logic [IW-1:0] idx, input logic pil_on);
      int   b;
      int   u;
      bin_t c;
      b = 32'(idx);
      u = 32'sd0;
      if ((b >= 32'sd1) && (b <= H)) begin
         u = b - 32'sd1;
         c = (pil_on && ((u % PILOT_SPACING) == PILOT_OFFSET)) ? BIN_PILOT : BIN_DATA;
      end else if (b >= (NFFT - H)) begin
         u = b - (NFFT - H) + H;
         c = (pil_on && ((u % PILOT_SPACING) == PILOT_OFFSET)) ? BIN_PILOT : BIN_DATA;
      end else begin
         c = BIN_NULL;
      end
      return c;
   endfunction

   state_t                  state_r;
   logic [IW-1:0]           idx_r;
   logic [6:0]              lfsr_r;
   logic                    pilot_on_r;
   logic                    pilot_neg_r;
   logic signed [WIDTH-1:0] out_i_r;
   logic signed [WIDTH-1:0] out_q_r;
   logic [IW-1:0]           out_idx_r;
   logic                    out_valid_r;
   logic                    out_sop_r;
   logic                    out_eop_r;

   bin_t                    bin_cls_s;
   logic                    is_data_s;
   logic                    can_load_s;
   logic                    advance_s;
   logic                    lfsr_fb_s;
   logic signed [WIDTH-1:0] val_i_s;
   logic signed [WIDTH-1:0] val_q_s;

   assign bin_cls_s  = classify(idx_r, pilot_on_r);
   assign is_data_s  = (bin_cls_s == BIN_DATA);
   assign can_load_s = en && (state_r == ST_MAP) && (!out_valid_r || bus.out_ready);
   assign advance_s  = can_load_s && (!is_data_s || bus.in_valid);
   assign lfsr_fb_s  = lfsr_r[6] ^ lfsr_r[3];

   // Value presented for the current bin.
   always_comb begin
      val_i_s = {WIDTH{1'b0}};
      val_q_s = {WIDTH{1'b0}};
      case (bin_cls_s)
         BIN_DATA: begin
            val_i_s = bus.in_i;
            val_q_s = bus.in_q;
         end
         BIN_PILOT: begin
            val_i_s = pilot_neg_r ? PILOT_NEG : PILOT_POS;
            val_q_s = {WIDTH{1'b0}};
         end
         default: begin
            val_i_s = {WIDTH{1'b0}};
            val_q_s = {WIDTH{1'b0}};
         end
      endcase
   end

   // Symbol sequencing: bin counter, per-symbol pilot enable and polarity LFSR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= {IW{1'b0}};
         lfsr_r      <= 7'h7F;
         pilot_on_r  <= 1'b0;
         pilot_neg_r <= 1'b0;
      end else if (en) begin
         case (state_r)
            ST_IDLE: begin
               idx_r <= {IW{1'b0}};
               if (bus.in_valid) begin
                  pilot_on_r  <= pilot_en;
                  lfsr_r      <= {lfsr_r[5:0], lfsr_fb_s};
                  pilot_neg_r <= lfsr_fb_s;
                  state_r     <= ST_MAP;
               end
            end
            ST_MAP: begin
               if (advance_s) begin
                  if (idx_r == LAST_IDX) begin
                     idx_r   <= {IW{1'b0}};
                     state_r <= ST_IDLE;
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= {IW{1'b0}};
            end
         endcase
      end
   end

   // Output register: loads on advance, drains when the sink accepts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_i_r     <= {WIDTH{1'b0}};
         out_q_r     <= {WIDTH{1'b0}};
         out_idx_r   <= {IW{1'b0}};
         out_valid_r <= 1'b0;
         out_sop_r   <= 1'b0;
         out_eop_r   <= 1'b0;
      end else if (en) begin
         if (advance_s) begin
            out_i_r     <= val_i_s;
            out_q_r     <= val_q_s;
            out_idx_r   <= idx_r;
            out_sop_r   <= (idx_r == {IW{1'b0}});
            out_eop_r   <= (idx_r == LAST_IDX);
            out_valid_r <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = can_load_s && is_data_s;
   assign bus.out_i     = out_i_r;
   assign bus.out_q     = out_q_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sop   = out_sop_r;
   assign bus.out_eop   = out_eop_r;
endmodule

// File: tb/tb_ofdm_symbol_mapper.sv
// Directed bench for ofdm_symbol_mapper: default 64-bin instance plus a
// 16-bin instance, checked against hand tables and a small bin-plan model.
module tb_ofdm_symbol_mapper;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b1;
   logic pilot_en = 1'b1;
   logic pilot_en2 = 1'b1;

   always #5 clk = ~clk;

   ofdm_symbol_mapper_if #(.WIDTH(16), .NFFT(64)) bus ();
   ofdm_symbol_mapper_if #(.WIDTH(16), .NFFT(16)) bus2 ();

   ofdm_symbol_mapper #(.WIDTH(16), .NFFT(64), .NUSED(52), .PILOT_SPACING(13),
                        .PILOT_OFFSET(6), .PILOT_AMP(8192))
      dut (.clk(clk), .rst(rst), .en(en), .pilot_en(pilot_en), .bus(bus));

   ofdm_symbol_mapper #(.WIDTH(16), .NFFT(16), .NUSED(12), .PILOT_SPACING(4),
                        .PILOT_OFFSET(1), .PILOT_AMP(8192))
      dut2 (.clk(clk), .rst(rst), .en(en), .pilot_en(pilot_en2), .bus(bus2));

   typedef struct {
      int bin;
      int ei;
      int eq;
      int esop;
      int eeop;
   } vec_t;

   vec_t vecs[12];
   int   n_chk = 0;
   int   n_fail = 0;
   int   vpct = 100;
   int   rpct = 100;
   int   src_k = 1;
   int   in_left = 0;
   int   cyc = 0;
   int   sym_cnt = 0;
   int   cap_n = 0;
   int   cap_i[512];
   int   cap_q[512];
   int   cap_idx[512];
   int   cap_sop[512];
   int   cap_eop[512];
   int   cap_cyc[512];
   int   exp_i[64];
   int   exp_q[64];
   int   e16_i[16] = '{0, 1, 8192, 2, 3, 4, 8192, 0, 0, 0, 5, 6, 7, 8192, 8, 9};
   int   e16_q[16] = '{0, -1, 0, -2, -3, -4, 0, 0, 0, 0, -5, -6, -7, 0, -8, -9};

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", name, act, req);
      end
   endtask

   function automatic bit lfsr_sign(input int n);
      logic [6:0] l;
      bit b;
      l = 7'h7F;
      b = 1'b0;
      for (int j = 0; j <= n; j++) begin
         b = l[6] ^ l[3];
         l = {l[5:0], b};
      end
      return b;
   endfunction

   // Bin plan for the default instance: DC at 0, guard 27..37, pilots 7/20/44/57.
   task automatic build_model(input bit pil_on, input bit neg, inout int k);
      for (int b = 0; b < 64; b++) begin
         if (b == 0 || (b >= 27 && b <= 37)) begin
            exp_i[b] = 0;
            exp_q[b] = 0;
         end else if (pil_on && (b == 7 || b == 20 || b == 44 || b == 57)) begin
            exp_i[b] = neg ? -8192 : 8192;
            exp_q[b] = 0;
         end else begin
            exp_i[b] = k;
            exp_q[b] = -k;
            k++;
         end
      end
   endtask

   task automatic cycle();
      bit   in_fire, out_fire, hold;
      int   s_iq, s_ctl, o_i, o_q, o_idx, o_sop, o_eop;
      bus.in_valid  = (in_left > 0) && ($urandom_range(99) < vpct);
      bus.in_i      = 16'(src_k);
      bus.in_q      = 16'(-src_k);
      bus.out_ready = ($urandom_range(99) < rpct);
      #1;
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready && en;
      hold     = !en || (bus.out_valid && !bus.out_ready);
      s_iq     = 32'({bus.out_i, bus.out_q});
      s_ctl    = 32'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_idx});
      o_i      = int'(bus.out_i);
      o_q      = int'(bus.out_q);
      o_idx    = 32'(bus.out_idx);
      o_sop    = 32'(bus.out_sop);
      o_eop    = 32'(bus.out_eop);
      if (!en) check("en_low_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      cyc++;
      if (out_fire && cap_n < 512) begin
         cap_i[cap_n]   = o_i;
         cap_q[cap_n]   = o_q;
         cap_idx[cap_n] = o_idx;
         cap_sop[cap_n] = o_sop;
         cap_eop[cap_n] = o_eop;
         cap_cyc[cap_n] = cyc;
         cap_n++;
      end
      if (in_fire) begin
         src_k++;
         in_left--;
      end
      if (hold) begin
         check("hold_iq", 32'({bus.out_i, bus.out_q}), s_iq);
         check("hold_ctl", 32'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_idx}), s_ctl);
      end
   endtask

   task automatic run_beats(input int target, input int budget, input string name);
      int c;
      c = 0;
      while (cap_n < target && c < budget) begin
         cycle();
         c++;
      end
      if (cap_n < target)
         $display("FAIL %s timeout: actual %0d beats, required %0d", name, cap_n, target);
      check("beats_collected", cap_n >= target ? target : cap_n, target);
   endtask

   task automatic check_sym(input int base, input bit pil_on, inout int k);
      bit neg;
      neg = lfsr_sign(sym_cnt);
      sym_cnt++;
      build_model(pil_on, neg, k);
      check("sym_present", (base + 64 <= cap_n) ? 1 : 0, 1);
      for (int b = 0; b < 64; b++) begin
         n_chk++;
         if (cap_idx[base+b] != b || cap_i[base+b] != exp_i[b] || cap_q[base+b] != exp_q[b] ||
             cap_sop[base+b] != ((b == 0) ? 1 : 0) || cap_eop[base+b] != ((b == 63) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL beat base=%0d bin=%0d: actual idx=%0d i=%0d q=%0d sop=%0d eop=%0d, required i=%0d q=%0d",
                     base, b, cap_idx[base+b], cap_i[base+b], cap_q[base+b],
                     cap_sop[base+b], cap_eop[base+b], exp_i[b], exp_q[b]);
         end
      end
   endtask

   initial begin
      int k, k2, n2;
      bit f_in, f_out;
      int s_i, s_q, s_idx, s_sop, s_eop;

      vecs[0]  = '{0, 0, 0, 1, 0};
      vecs[1]  = '{1, 1, -1, 0, 0};
      vecs[2]  = '{7, 8192, 0, 0, 0};
      vecs[3]  = '{8, 7, -7, 0, 0};
      vecs[4]  = '{20, 8192, 0, 0, 0};
      vecs[5]  = '{26, 24, -24, 0, 0};
      vecs[6]  = '{27, 0, 0, 0, 0};
      vecs[7]  = '{37, 0, 0, 0, 0};
      vecs[8]  = '{38, 25, -25, 0, 0};
      vecs[9]  = '{44, 8192, 0, 0, 0};
      vecs[10] = '{57, 8192, 0, 0, 0};
      vecs[11] = '{63, 48, -48, 0, 1};

      bus.in_valid = 1'b0; bus.in_i = 16'sd0; bus.in_q = 16'sd0; bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_i = 16'sd0; bus2.in_q = 16'sd0; bus2.out_ready = 1'b1;

      // Reset values, with traffic offered during reset.
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      #1;
      check("rst_out_i", int'(bus.out_i), 0);
      check("rst_out_q", int'(bus.out_q), 0);
      check("rst_out_idx", 32'(bus.out_idx), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_sop", 32'(bus.out_sop), 0);
      check("rst_out_eop", 32'(bus.out_eop), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Five back-to-back symbols with pilots.
      sym_cnt = 0; cap_n = 0; src_k = 1; in_left = 240; pilot_en = 1'b1;
      run_beats(320, 400, "five_sym");
      k = 1;
      for (int s = 0; s < 5; s++) check_sym(64 * s, 1'b1, k);
      for (int v = 0; v < 12; v++) begin
         check("tbl_i", cap_i[vecs[v].bin], vecs[v].ei);
         check("tbl_q", cap_q[vecs[v].bin], vecs[v].eq);
         check("tbl_sop", cap_sop[vecs[v].bin], vecs[v].esop);
         check("tbl_eop", cap_eop[vecs[v].bin], vecs[v].eeop);
      end
      check("sym3_pilot", cap_i[3*64+7], 8192);
      check("sym4_pilot", cap_i[4*64+7], -8192);
      for (int s = 1; s < 5; s++) check("sym_period", cap_cyc[64*s] - cap_cyc[64*(s-1)], 65);

      // Reset in the middle of the sixth symbol.
      in_left = 48;
      run_beats(350, 60, "sym5_partial");
      rst = 1'b0; in_left = 0;
      #1;
      check("rst_mid_valid", 32'(bus.out_valid), 0);
      check("rst_mid_idx", 32'(bus.out_idx), 0);
      repeat (2) cycle();
      rst = 1'b1;
      cap_n = 0; sym_cnt = 0; src_k = 1; in_left = 48;
      run_beats(64, 100, "after_rst");
      k = 1;
      check_sym(0, 1'b1, k);
      check("rst_restart_idx", cap_idx[0], 0);
      check("rst_restart_pilot", cap_i[7], 8192);

      // Pilots off, then pilot_en raised mid-symbol.
      pilot_en = 1'b0; cap_n = 0; src_k = 1; in_left = 52 + 52 + 48;
      run_beats(74, 120, "nopilot_a");
      pilot_en = 1'b1;
      run_beats(192, 200, "nopilot_b");
      k = 1;
      check_sym(0, 1'b0, k);
      check("nopilot_bin7", cap_i[7], 7);
      check_sym(64, 1'b0, k);
      check_sym(128, 1'b1, k);
      check("nopilot_consumed", src_k, 153);

      // Random gaps on both sides.
      cap_n = 0; src_k = 1; in_left = 96; vpct = 30; rpct = 50;
      run_beats(128, 4000, "gaps");
      vpct = 100; rpct = 100;
      k = 1;
      check_sym(0, 1'b1, k);
      check_sym(64, 1'b1, k);
      check("gap_consumed", src_k, 97);

      // Clock enable low mid-symbol and in IDLE.
      cap_n = 0; src_k = 1; in_left = 48;
      run_beats(20, 40, "en_pre");
      en = 1'b0;
      repeat (3) cycle();
      check("en_low_no_beats", cap_n, 20);
      en = 1'b1;
      run_beats(64, 100, "en_post");
      k = 1;
      check_sym(0, 1'b1, k);
      en = 1'b0; in_left = 48;
      repeat (3) cycle();
      check("idle_en_low_valid", 32'(bus.out_valid), 0);
      check("idle_en_low_beats", cap_n, 64);
      en = 1'b1;
      run_beats(128, 100, "en_idle_post");
      check_sym(64, 1'b1, k);

      // 16-bin instance: pilots at 2, 6, 13; guard 7..9.
      k2 = 1; n2 = 0; pilot_en2 = 1'b1;
      for (int c = 0; c < 60 && n2 < 16; c++) begin
         bus2.in_valid  = (k2 <= 9);
         bus2.in_i      = 16'(k2);
         bus2.in_q      = 16'(-k2);
         bus2.out_ready = 1'b1;
         #1;
         f_in  = bus2.in_valid && bus2.in_ready;
         f_out = bus2.out_valid && bus2.out_ready;
         s_i   = int'(bus2.out_i);
         s_q   = int'(bus2.out_q);
         s_idx = 32'(bus2.out_idx);
         s_sop = 32'(bus2.out_sop);
         s_eop = 32'(bus2.out_eop);
         @(posedge clk);
         #1;
         if (f_out) begin
            check("n16_idx", s_idx, n2);
            check("n16_i", s_i, e16_i[n2]);
            check("n16_q", s_q, e16_q[n2]);
            check("n16_sop", s_sop, (n2 == 0) ? 1 : 0);
            check("n16_eop", s_eop, (n2 == 15) ? 1 : 0);
            n2++;
         end
         if (f_in) k2++;
      end
      check("n16_beats", n2, 16);
      check("n16_consumed", k2, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
